ps2_rx_port: RTL and testbench
==============================

// Module: ps2_rx_port
// PURPOSE
//  Receive-only PS/2 host port. Samples the external PS/2 clock and data lines,
//  deframes 11-bit device-to-host frames, strips the E0/F0 prefixes and presents
//  one decoded scancode per key event with a 1-cycle strobe. Sits between the
//  keyboard/mouse pins and keyboard-command logic such as the mode/test selector.
// PARAMETERS
//  FILTER_LEN      8        consecutive equal samples required to accept a ps2clk level
//  TIMEOUT_CYCLES  100000   idle clk cycles inside a frame before it is aborted (~2 ms @ 50 MHz)
// PORTS
//  clk           in   1  system clock, 1 MHz..600 MHz; all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  enable_rcv    in   1  1 = receiver running; 0 = hold idle, ignore line activity
//  kb_or_mouse   in   1  0 = keyboard (prefix decoding); 1 = mouse (raw bytes)
//  ps2clk_ext    in   1  PS/2 clock pin, asynchronous
//  ps2data_ext   in   1  PS/2 data pin, asynchronous
//  kb_interrupt  out  1  high for exactly one clk when a new event is presented
//  scancode      out  8  make/break code of the event (prefix bytes removed)
//  released      out  1  1 = break (F0 seen), 0 = make
//  extended      out  1  1 = E0 seen, 0 = normal key
// BEHAVIOUR
//  - One clock domain: clk. Reset is synchronous and active-high.
//  - Reset: kb_interrupt=0, scancode=8'h00, released=0, extended=0; prefix flags
//    cleared; frame state IDLE; bit counter 0; filters preset to 1 (idle bus).
//  - Both pins pass a 2-FF synchronizer. ps2clk then passes a FILTER_LEN-sample
//    glitch filter; a filtered 1->0 transition is a falling edge. Data is sampled
//    (synchronized value) on that edge.
//  - Frame FSM: IDLE -> (edge, data=0 start) RECV -> 8 data bits, LSB first ->
//    PARITY -> STOP -> IDLE. Start bit = 1 is ignored (stay IDLE).
//  - Valid frame: odd parity over data+parity bit, stop=1. Invalid frame: byte
//    discarded, no strobe, prefix flags unchanged, FSM back to IDLE.
//  - Watchdog: counter cleared on every falling edge; if it reaches
//    TIMEOUT_CYCLES while not IDLE, frame aborted to IDLE, nothing emitted.
//  - Keyboard mode (kb_or_mouse=0), on a valid byte:
//      E0 -> set ext flag, no strobe; F0 -> set rel flag, no strobe;
//      other -> scancode<=byte, extended<=ext flag, released<=rel flag,
//      kb_interrupt<=1 next cycle, both flags cleared.
//  - Mouse mode (kb_or_mouse=1): every valid byte presented with released=0,
//    extended=0, strobe; prefix flags held cleared.
//  - Latency: strobe asserted exactly 1 clk after the stop-bit falling edge.
//  - scancode/released/extended hold value until the next event.
//  - enable_rcv=0: FSM forced IDLE, flags cleared, no strobes; a frame in
//    progress is lost. Re-enable takes effect on the next start bit.
//  - kb_or_mouse change mid-frame: mode sampled when the byte completes.
//  - rst mid-frame: frame dropped, all reset values restored.
// STRUCTURE
//  - Shared package: frame-state enum (IDLE, RECV, PARITY, STOP), prefix
//    constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
//  - Sub-module ps2_sync_filter (2-FF sync + glitch filter + falling-edge
//    pulse); deframer, watchdog and prefix decoder in the top.
// TESTING
//  - Kbd mode, send 0x1C (odd parity ok) -> one strobe, scancode=1C,
//    released=0, extended=0.
//  - Send F0,16 -> single strobe after 16 frame only, scancode=16, released=1,
//    extended=0; next byte 1E -> released=0.
//  - Send E0,F0,75 -> scancode=75, released=1, extended=1; flags clear afterwards.
//  - Bad parity on 0x29 -> no strobe, outputs unchanged; stop gap > TIMEOUT_CYCLES
//    after 4 bits then full 0x29 frame -> one strobe with scancode=29.
//  - Mouse mode, send F0 then 08 -> two strobes, scancode F0 then 08,
//    released=extended=0 both times.
//  - enable_rcv=0 during full 0x1C frame -> no strobe; 1-clk glitches on
//    ps2clk_ext (shorter than FILTER_LEN) -> no bit consumed.

Source files
------------

// File: rtl/ps2_rx_port_pkg.sv
// ps2_rx_port_pkg: frame states, prefix bytes and frame validity helper for the PS/2 receiver.
package ps2_rx_port_pkg;
  typedef enum logic [1:0] {IDLE, RECV, PARITY, STOP} frame_state_e;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  function automatic logic frame_ok(input logic [7:0] b, input logic par, input logic stop);
    return stop & (^{b, par});
  endfunction
endpackage

// File: rtl/ps2_rx_port_sync_filter.sv
// ps2_sync_filter: synchronizes both PS/2 pins, deglitches the clock and pulses on its falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2clk_i,
  input  logic ps2data_i,
  output logic data_o,
  output logic fall_o
);
  logic [1:0] csync_q, dsync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic filt_q, filt_d, fall_q;
  // the filtered level only moves once the whole history agrees
  always_comb filt_d = &hist_q ? 1'b1 : ~|hist_q ? 1'b0 : filt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      csync_q <= '1;
      dsync_q <= '1;
      hist_q  <= '1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      csync_q <= {csync_q[0], ps2clk_i};
      dsync_q <= {dsync_q[0], ps2data_i};
      hist_q  <= {hist_q[FILTER_LEN-2:0], csync_q[1]};
      filt_q  <= filt_d;
      fall_q  <= filt_q & ~filt_d;
    end
  end
  assign data_o = dsync_q[1];
  assign fall_o = fall_q;
endmodule

// File: rtl/ps2_rx_port.sv
// ps2_rx_port: PS/2 receive port; deframes device frames, strips E0/F0 prefixes, strobes one event per key.
module ps2_rx_port
  import ps2_rx_port_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_rcv,
  input  logic       kb_or_mouse,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       kb_interrupt,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  frame_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d, sc_q, sc_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic par_q, par_d, ext_q, ext_d, rel_q, rel_d;
  logic released_q, released_d, extended_q, extended_d, int_q, int_d;
  logic din, fall;
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk(clk), .rst(rst), .ps2clk_i(ps2clk_ext), .ps2data_i(ps2data_ext),
    .data_o(din), .fall_o(fall)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      sc_q       <= '0;
      released_q <= 1'b0;
      extended_q <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      sc_q       <= sc_d;
      released_q <= released_d;
      extended_q <= extended_d;
      int_q      <= int_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    par_d      = par_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    sc_d       = sc_q;
    released_d = released_q;
    extended_d = extended_q;
    int_d      = 1'b0;
    wd_d       = (fall || state_q == IDLE) ? '0 : wd_q + WD_W'(1);
    case (state_q)
      IDLE:   if (fall && !din) begin
        state_d = RECV;
        cnt_d   = '0;
      end
      RECV:   if (fall) begin
        byte_d  = {din, byte_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? PARITY : RECV;
      end
      PARITY: if (fall) begin
        par_d   = din;
        state_d = STOP;
      end
      STOP:   if (fall) begin
        state_d = IDLE;
        if (frame_ok(byte_q, par_q, din)) begin
          if (!kb_or_mouse && byte_q == PS2_EXT) ext_d = 1'b1;
          else if (!kb_or_mouse && byte_q == PS2_BRK) rel_d = 1'b1;
          else begin
            sc_d       = byte_q;
            extended_d = ext_q & ~kb_or_mouse;
            released_d = rel_q & ~kb_or_mouse;
            int_d      = 1'b1;
            ext_d      = 1'b0;
            rel_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a stalled device must not leave the deframer stuck mid-frame
    if (state_q != IDLE && !fall && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
    if (kb_or_mouse) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
    if (!enable_rcv) begin
      state_d = IDLE;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
      int_d   = 1'b0;
    end
  end
  assign kb_interrupt = int_q;
  assign scancode     = sc_q;
  assign released     = released_q;
  assign extended     = extended_q;
endmodule

// File: tb/tb_ps2_rx_port.sv
// tb_ps2_rx_port: scoreboard bench driving PS/2 frames and checking every presented key event.
module tb_ps2_rx_port;
  logic clk = 1'b0;
  logic rst, enable_rcv, kb_or_mouse, ps2clk_ext, ps2data_ext;
  logic kb_interrupt, released, extended;
  logic [7:0] scancode;
  logic [9:0] sb[$];
  logic prev_int = 1'b0;
  int checks = 0, fails = 0, nstrobe = 0;

  ps2_rx_port #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .enable_rcv(enable_rcv), .kb_or_mouse(kb_or_mouse),
    .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext), .kb_interrupt(kb_interrupt),
    .scancode(scancode), .released(released), .extended(extended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] sc, input logic rel, input logic ext);
    sb.push_back({sc, rel, ext});
  endtask

  // frame bits: start 0, data LSB first, odd parity, stop 1
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data_ext = fr[i];
      repeat (20) @(posedge clk);
      ps2clk_ext = 1'b0;
      repeat (40) @(posedge clk);
      ps2clk_ext = 1'b1;
      repeat (10) @(posedge clk);
      if (glitch) begin
        ps2clk_ext = 1'b0;
        @(posedge clk);
        ps2clk_ext = 1'b1;
      end
      repeat (10) @(posedge clk);
    end
    ps2data_ext = 1'b1;
  endtask

  always @(negedge clk) begin
    if (kb_interrupt) begin
      nstrobe++;
      chk("strobe_width", {31'b0, prev_int}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: got sc=%h rel=%b ext=%b expected no event", scancode, released, extended);
      end else chk("event", {22'b0, scancode, released, extended}, {22'b0, sb.pop_front()});
    end
    prev_int = kb_interrupt;
  end

  initial begin
    rst = 1'b1; enable_rcv = 1'b1; kb_or_mouse = 1'b0; ps2clk_ext = 1'b1; ps2data_ext = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_int", {31'b0, kb_interrupt}, 32'd0);
    chk("rst_scancode", {24'b0, scancode}, 32'h00);
    chk("rst_released", {31'b0, released}, 32'd0);
    chk("rst_extended", {31'b0, extended}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 0, 11, 0);
    expect_ev(8'h16, 1'b1, 1'b0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h16, 0, 11, 0);
    expect_ev(8'h1E, 1'b0, 1'b0);
    send_frame(8'h1E, 0, 11, 0);
    expect_ev(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h75, 0, 11, 0);
    send_frame(8'h29, 1, 11, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("held_scancode", {24'b0, scancode}, 32'h75);
    chk("held_released", {31'b0, released}, 32'd1);
    chk("held_extended", {31'b0, extended}, 32'd1);
    send_frame(8'h29, 0, 4, 0);
    repeat (2500) @(posedge clk);
    expect_ev(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 0, 11, 0);
    enable_rcv = 1'b0;
    send_frame(8'h1C, 0, 11, 0);
    repeat (10) @(posedge clk);
    enable_rcv = 1'b1;
    repeat (10) @(posedge clk);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 0, 11, 1);
    kb_or_mouse = 1'b1;
    expect_ev(8'hF0, 1'b0, 1'b0);
    send_frame(8'hF0, 0, 11, 0);
    expect_ev(8'h08, 1'b0, 1'b0);
    send_frame(8'h08, 0, 11, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("pending_events", sb.size(), 32'd0);
    chk("strobe_count", nstrobe, 32'd8);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
